// File: rtl/pad_mux_switch_seq_if.sv
// Pad mux sequencer bus: groups the register-file side request signals and the
// pad-ring side outputs of pad_mux_switch_seq.
//   master : pad control register file / pad ring consumer (drives requests)
//   slave  : pad_mux_switch_seq (drives applied selects, OE enables, status)
// Signals:
//   pad_muxes_req_i [NUM_PAD] requested mux select per pad
//   freeze_i                  1 = do not start a new batch
//   pad_muxes_o     [NUM_PAD] applied mux select per pad
//   pad_oe_en_o     [NUM_PAD] 1 = pad driver allowed, 0 = forced tristate
//   busy_o                    sequencer not idle
//   switch_done_o             one-cycle batch done pulse
interface pad_mux_switch_seq_if #(
  parameter int NUM_PAD = 14
);
  logic [NUM_PAD-1:0] pad_muxes_req_i;
  logic               freeze_i;
  logic [NUM_PAD-1:0] pad_muxes_o;
  logic [NUM_PAD-1:0] pad_oe_en_o;
  logic               busy_o;
  logic               switch_done_o;

  modport master (
    output pad_muxes_req_i, freeze_i,
    input  pad_muxes_o, pad_oe_en_o, busy_o, switch_done_o
  );

  modport slave (
    input  pad_muxes_req_i, freeze_i,
    output pad_muxes_o, pad_oe_en_o, busy_o, switch_done_o
  );
endinterface

// File: rtl/pad_mux_switch_seq.sv
// Glitch-free pad mux reconfiguration sequencer.
// Every pad whose requested select differs from the applied one has its output
// enable gated off, waits GUARD_CYCLES, has its mux switched, waits
// SETTLE_CYCLES, then is re-enabled. Pads changing together form one batch.
// Ports:
//   clk_i   system clock
//   rst_ni  asynchronous active-low reset
//   bus     pad_mux_switch_seq_if.slave (requests in; selects, OE, busy, done out)
// Optional feature macro: PAD_MUX_SEQ_DONE_PULSE_EN
//   defined     -> switch_done_o is a registered one-cycle pulse on SETTLE->IDLE
//   not defined -> switch_done_o tied to 0
module pad_mux_switch_seq #(
  parameter int NUM_PAD       = 14,
  parameter int GUARD_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  pad_mux_switch_seq_if.slave bus
);

  localparam int MAX_CYC = (GUARD_CYCLES > SETTLE_CYCLES) ? GUARD_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_GATE   = 2'd1;
  localparam logic [1:0] ST_SWITCH = 2'd2;
  localparam logic [1:0] ST_SETTLE = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_PAD-1:0] pend_mask_q, pend_mask_d;
  logic [NUM_PAD-1:0] pend_val_q, pend_val_d;
  logic [NUM_PAD-1:0] mux_q, mux_d;
  logic               busy_q, busy_d;
  logic [NUM_PAD-1:0] diff;

  assign diff = bus.pad_muxes_req_i ^ mux_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_mask_d = pend_mask_q;
    pend_val_d  = pend_val_q;
    mux_d       = mux_q;
    case (state_q)
      ST_IDLE: begin
        if ((|diff) && !bus.freeze_i) begin
          pend_mask_d = diff;
          pend_val_d  = bus.pad_muxes_req_i;
          cnt_d       = CNT_W'(GUARD_CYCLES - 1);
          state_d     = ST_GATE;
        end
      end
      ST_GATE: begin
        if (cnt_q == '0) state_d = ST_SWITCH;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_SWITCH: begin
        mux_d   = (mux_q & ~pend_mask_q) | (pend_val_q & pend_mask_q);
        cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          // Clearing the mask here is what restores OE on entry to IDLE.
          pend_mask_d = '0;
          pend_val_d  = '0;
          state_d     = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      pend_mask_q <= '0;
      pend_val_q  <= '0;
      mux_q       <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_mask_q <= pend_mask_d;
      pend_val_q  <= pend_val_d;
      mux_q       <= mux_d;
      busy_q      <= busy_d;
    end
  end

  // OE is the inverse of a flop output, so it cannot glitch; mask is zero in IDLE.
  assign bus.pad_muxes_o = mux_q;
  assign bus.pad_oe_en_o = ~pend_mask_q;
  assign bus.busy_o      = busy_q;

`ifdef PAD_MUX_SEQ_DONE_PULSE_EN
  logic done_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) done_q <= 1'b0;
    else         done_q <= (state_q == ST_SETTLE) && (cnt_q == '0);
  end

  assign bus.switch_done_o = done_q;
`else
  assign bus.switch_done_o = 1'b0;
`endif

endmodule

// File: tb/tb_pad_mux_switch_seq.sv
module tb_pad_mux_switch_seq;

`ifdef PAD_MUX_SEQ_DONE_PULSE_EN
  localparam bit DONE_EN = 1'b1;
`else
  localparam bit DONE_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  pad_mux_switch_seq_if #(.NUM_PAD(14)) bus ();

  pad_mux_switch_seq #(
    .NUM_PAD      (14),
    .GUARD_CYCLES (4),
    .SETTLE_CYCLES(2)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] req;
    logic        frz;
    int unsigned n;
    logic [13:0] mux;
    logic [13:0] oe;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [13:0] mux, input logic [13:0] oe,
                         input logic busy, input logic done);
    chk({tag, ".mux"},  32'(bus.pad_muxes_o),   32'(mux));
    chk({tag, ".oe"},   32'(bus.pad_oe_en_o),   32'(oe));
    chk({tag, ".busy"}, 32'(bus.busy_o),        32'(busy));
    chk({tag, ".done"}, 32'(bus.switch_done_o), 32'(DONE_EN & done));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.pad_muxes_req_i = 14'h0;
    bus.freeze_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // 0..1 from reset: 0->0x2081 (bits 0,7,13), gated and switched together
    tbl[0] = '{14'h2081, 1'b0, 1,  14'h0000, 14'h1F7E, 1'b1, 1'b0};
    tbl[1] = '{14'h2081, 1'b0, 5,  14'h2081, 14'h1F7E, 1'b1, 1'b0};
    tbl[2] = '{14'h2081, 1'b0, 2,  14'h2081, 14'h3FFF, 1'b0, 1'b1};
    tbl[3] = '{14'h2081, 1'b0, 3,  14'h2081, 14'h3FFF, 1'b0, 1'b0};
    tbl[4] = '{14'h2080, 1'b1, 5,  14'h2081, 14'h3FFF, 1'b0, 1'b0};
    tbl[5] = '{14'h2080, 1'b0, 1,  14'h2081, 14'h3FFE, 1'b1, 1'b0};
    tbl[6] = '{14'h2080, 1'b0, 7,  14'h2080, 14'h3FFF, 1'b0, 1'b1};
    tbl[7] = '{14'h2090, 1'b1, 20, 14'h2080, 14'h3FFF, 1'b0, 1'b0};
    tbl[8] = '{14'h2090, 1'b0, 1,  14'h2080, 14'h3FEF, 1'b1, 1'b0};
    tbl[9] = '{14'h2090, 1'b0, 7,  14'h2090, 14'h3FFF, 1'b0, 1'b1};

    // Reset with arbitrary request held
    rst_n = 1'b0;
    bus.pad_muxes_req_i = 14'h1555;
    bus.freeze_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all("reset", 14'h0000, 14'h3FFF, 1'b0, 1'b0);
    @(negedge clk);
    bus.pad_muxes_req_i = 14'h0000;
    rst_n = 1'b1;

    // Single pad bit 3: 7-cycle OE window, mux at k+5, done at k+7
    @(negedge clk);
    bus.pad_muxes_req_i = 14'h0008;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      chk_all($sformatf("bit3.c%0d", c),
              (c >= 5) ? 14'h0008 : 14'h0000,
              (c < 7)  ? 14'h3FF7 : 14'h3FFF,
              c < 7, c == 7);
    end

    // Table-driven vectors
    do_reset();
    foreach (tbl[i]) begin
      @(negedge clk);
      bus.pad_muxes_req_i = tbl[i].req;
      bus.freeze_i = tbl[i].frz;
      repeat (tbl[i].n) @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), tbl[i].mux, tbl[i].oe, tbl[i].busy, tbl[i].done);
    end

    // Mid-batch request change: bit 5 waits for a second batch
    do_reset();
    @(negedge clk);
    bus.pad_muxes_req_i = 14'h0008;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      chk_all($sformatf("mid.c%0d", c),
              (c >= 13) ? 14'h0028 : (c >= 5) ? 14'h0008 : 14'h0000,
              (c < 7) ? 14'h3FF7 : (c >= 8 && c < 15) ? 14'h3FDF : 14'h3FFF,
              (c < 7) || (c >= 8 && c < 15),
              (c == 7) || (c == 15));
      if (c == 1) bus.pad_muxes_req_i = 14'h0028;
    end

    // Request wanders mid-batch and returns to the batch value: no second batch
    @(negedge clk);
    bus.pad_muxes_req_i = 14'h0029;
    for (int c = 0; c < 9; c++) begin
      @(posedge clk); #1;
      chk_all($sformatf("rev.c%0d", c),
              (c >= 5) ? 14'h0029 : 14'h0028,
              (c < 7) ? 14'h3FFE : 14'h3FFF,
              c < 7, c == 7);
      if (c == 1) bus.pad_muxes_req_i = 14'h0039;
      if (c == 3) bus.pad_muxes_req_i = 14'h0029;
    end

    // Reset asserted mid-GATE, then a fresh full batch
    do_reset();
    @(negedge clk);
    bus.pad_muxes_req_i = 14'h0010;
    @(posedge clk); #1;
    chk_all("rg.start", 14'h0000, 14'h3FEF, 1'b1, 1'b0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk_all("rg.async", 14'h0000, 14'h3FFF, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk_all("rg.hold", 14'h0000, 14'h3FFF, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      chk_all($sformatf("rg.c%0d", c),
              (c >= 5) ? 14'h0010 : 14'h0000,
              (c < 7)  ? 14'h3FEF : 14'h3FFF,
              c < 7, c == 7);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
